// File: rtl/seq_calculator.sv
// Multi-cycle unsigned calculator: add/sub in 1 cycle, shift-add multiply and restoring divide in WIDTH cycles.
// Optional CALC_SATURATE_EN clamps add overflow to all ones and sub borrow to zero.
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [1:0]           i_sel_op,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_result,
  output logic [WIDTH-1:0]     o_remainder,
  output logic                 o_carry,
  output logic                 o_div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [2*WIDTH-1:0]   acc_q, acc_nxt;
  logic [WIDTH-1:0]     rem_q, rem_nxt;
  logic [CW-1:0]        cnt_q;

  logic                 accept, short_op, last;
  logic [WIDTH:0]       sum_ab, diff_ab, mul_sum, shifted, trial;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH-1:0]     quo_nxt;
  logic                 fits;

  logic [2*WIDTH-1:0]   res_nxt;
  logic [WIDTH-1:0]     remo_nxt;
  logic                 carry_nxt, dz_nxt;

  assign accept   = i_start && (state == IDLE || state == DONE);
  assign short_op = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                    (op_q == OP_DIV && b_q == '0);
  assign last     = (state == RUN) && (short_op || cnt_q == CW'(WIDTH - 1));

  assign o_busy = (state == RUN);
  assign o_done = (state == DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (last)    state_nxt = DONE;
      DONE:    state_nxt = i_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration of each multi-cycle algorithm. The multiplier sits in the low
  // half of acc_q and is shifted out as the partial product grows in the high half.
  // For divide, the low half holds the dividend shifting out MSB first while the
  // quotient bits shift in behind it.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

    shifted = {rem_q, acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    fits    = !trial[WIDTH];
    rem_nxt = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {acc_q[WIDTH-2:0], fits};

    acc_nxt = (op_q == OP_MUL) ? mul_nxt : {acc_q[2*WIDTH-1:WIDTH], quo_nxt};
  end

  assign sum_ab  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ab = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    res_nxt   = '0;
    remo_nxt  = '0;
    carry_nxt = 1'b0;
    dz_nxt    = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_nxt   = {{WIDTH{1'b0}}, sum_ab[WIDTH-1:0]};
        carry_nxt = sum_ab[WIDTH];
`ifdef CALC_SATURATE_EN
        if (sum_ab[WIDTH]) res_nxt = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
`endif
      end
      OP_SUB: begin
        res_nxt   = {{WIDTH{1'b0}}, diff_ab[WIDTH-1:0]};
        carry_nxt = diff_ab[WIDTH];
`ifdef CALC_SATURATE_EN
        if (diff_ab[WIDTH]) res_nxt = '0;
`endif
      end
      OP_MUL: res_nxt = mul_nxt;
      default: begin
        if (b_q == '0) begin
          remo_nxt = a_q;
          dz_nxt   = 1'b1;
        end else begin
          res_nxt  = {{WIDTH{1'b0}}, quo_nxt};
          remo_nxt = rem_nxt;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      op_q  <= i_sel_op;
      a_q   <= i_a;
      b_q   <= i_b;
      acc_q <= {{WIDTH{1'b0}}, (i_sel_op == OP_DIV) ? i_a : i_b};
      rem_q <= '0;
      cnt_q <= '0;
    end else if (state == RUN) begin
      acc_q <= acc_nxt;
      rem_q <= rem_nxt;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_result    <= '0;
      o_remainder <= '0;
      o_carry     <= 1'b0;
      o_div_zero  <= 1'b0;
    end else if (last) begin
      o_result    <= res_nxt;
      o_remainder <= remo_nxt;
      o_carry     <= carry_nxt;
      o_div_zero  <= dz_nxt;
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed bench for seq_calculator (WIDTH=8): scoreboard of expected results, checked at each o_done.
module tb_seq_calculator;

  localparam int W = 8;

  logic           i_clk, i_rst_n, i_start;
  logic [W-1:0]   i_a, i_b;
  logic [1:0]     i_sel_op;
  logic           o_busy, o_done, o_carry, o_div_zero;
  logic [2*W-1:0] o_result;
  logic [W-1:0]   o_remainder;

  typedef struct {
    logic [2*W-1:0] res;
    logic [W-1:0]   rem;
    logic           carry;
    logic           dz;
    int             lat;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   vectors = 0;
  int   miscompares = 0;

  seq_calculator #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_a(i_a), .i_b(i_b), .i_sel_op(i_sel_op),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_remainder(o_remainder), .o_carry(o_carry), .o_div_zero(o_div_zero)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input int a, input int b);
    exp_t e;
    int   t;
    e.res = '0; e.rem = '0; e.carry = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (op)
      2'b00: begin
        t = a + b;
        e.res = 16'(t % 256);
        e.carry = (t > 255);
`ifdef CALC_SATURATE_EN
        if (e.carry) e.res = 16'h00FF;
`endif
      end
      2'b01: begin
        t = a - b + 256;
        e.res = 16'(t % 256);
        e.carry = (a < b);
`ifdef CALC_SATURATE_EN
        if (e.carry) e.res = 16'h0000;
`endif
      end
      2'b10: begin
        e.res = 16'(a * b);
        e.lat = W;
      end
      default: begin
        if (b == 0) begin
          e.rem = 8'(a);
          e.dz  = 1'b1;
        end else begin
          e.res = 16'(a / b);
          e.rem = 8'(a % b);
          e.lat = W;
        end
      end
    endcase
    return e;
  endfunction

  task automatic scramble_inputs();
    i_a      = W'($urandom);
    i_b      = W'($urandom);
    i_sel_op = 2'($urandom);
  endtask

  // Called #1 after a posedge; drives one start pulse accepted on the next edge.
  task automatic issue(input logic [1:0] op, input int a, input int b);
    i_sel_op = op; i_a = W'(a); i_b = W'(b); i_start = 1'b1;
    sb.push_back(model(op, a, b));
    @(posedge i_clk); #1;
    i_start = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_done(input int poke_at);
    int   lat, busy_cnt;
    exp_t e;
    lat = 0; busy_cnt = 0;
    while (!o_done && lat < 64) begin
      if (o_busy) busy_cnt++;
      if (lat == poke_at) begin
        i_start = 1'b1; i_sel_op = 2'b00; i_a = 8'd1; i_b = 8'd1;
      end else if (poke_at >= 0 && lat == poke_at + 1) begin
        i_start = 1'b0;
      end
      @(posedge i_clk); #1;
      lat++;
    end
    chk("done_seen", {31'b0, o_done}, 32'd1);
    chk("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      last_exp = e;
      chk("latency", lat, e.lat);
      chk("busy_cycles", busy_cnt, e.lat);
      chk("result", {16'b0, o_result}, {16'b0, e.res});
      chk("remainder", {24'b0, o_remainder}, {24'b0, e.rem});
      chk("carry", {31'b0, o_carry}, {31'b0, e.carry});
      chk("div_zero", {31'b0, o_div_zero}, {31'b0, e.dz});
    end
  endtask

  task automatic check_hold();
    @(posedge i_clk); #1;
    chk("done_pulse_end", {31'b0, o_done}, 32'd0);
    chk("idle_not_busy", {31'b0, o_busy}, 32'd0);
    chk("result_held", {16'b0, o_result}, {16'b0, last_exp.res});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
    chk({tag, "_done"}, {31'b0, o_done}, 32'd0);
    chk({tag, "_result"}, {16'b0, o_result}, 32'd0);
    chk({tag, "_rem"}, {24'b0, o_remainder}, 32'd0);
    chk({tag, "_carry"}, {31'b0, o_carry}, 32'd0);
    chk({tag, "_dz"}, {31'b0, o_div_zero}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_a = '0; i_b = '0; i_sel_op = '0;
    #12;
    check_all_zero("reset");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_all_zero("post_reset");

    // add with carry, 1-cycle latency
    issue(2'b00, 200, 100); wait_done(-1); check_hold();
    issue(2'b01, 5, 9);     wait_done(-1); check_hold();
    issue(2'b00, 250, 10);  wait_done(-1); check_hold();
    issue(2'b00, 0, 0);     wait_done(-1); check_hold();
    issue(2'b01, 9, 9);     wait_done(-1); check_hold();

    // multiply corners
    issue(2'b10, 255, 255); wait_done(-1); check_hold();
    issue(2'b10, 0, 77);    wait_done(-1); check_hold();
    issue(2'b10, 77, 1);    wait_done(-1); check_hold();

    // divide, including divide by zero and divisor larger than dividend
    issue(2'b11, 100, 7);   wait_done(-1); check_hold();
    issue(2'b11, 9, 0);     wait_done(-1); check_hold();
    issue(2'b11, 3, 200);   wait_done(-1); check_hold();
    issue(2'b11, 255, 1);   wait_done(-1); check_hold();
    issue(2'b11, 255, 255); wait_done(-1); check_hold();

    // start pulsed mid-multiply must be ignored
    issue(2'b10, 255, 255); wait_done(3); check_hold();

    // reset in the middle of a divide aborts it
    issue(2'b11, 200, 3);
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    #1 check_all_zero("abort");
    sb.delete();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      chk("abort_no_done", {31'b0, o_done}, 32'd0);
    end
    issue(2'b00, 3, 4); wait_done(-1); check_hold();

    // start held through DONE: second op accepted with no IDLE cycle
    i_sel_op = 2'b00; i_a = 8'd10; i_b = 8'd20; i_start = 1'b1;
    sb.push_back(model(2'b00, 10, 20));
    @(posedge i_clk); #1;
    i_sel_op = 2'b10; i_a = 8'd12; i_b = 8'd13;
    wait_done(-1);
    sb.push_back(model(2'b10, 12, 13));
    @(posedge i_clk); #1;
    i_start = 1'b0;
    scramble_inputs();
    chk("b2b_busy", {31'b0, o_busy}, 32'd1);
    chk("b2b_done_low", {31'b0, o_done}, 32'd0);
    chk("b2b_result_held", {16'b0, o_result}, {16'b0, last_exp.res});
    wait_done(-1); check_hold();

    // random mix
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      int a, b;
      op = 2'($urandom);
      a  = int'($urandom_range(0, 255));
      b  = (i % 6 == 5) ? 0 : int'($urandom_range(0, 255));
      issue(op, a, b); wait_done(-1); check_hold();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
